// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the forwarding/interlock unit
package hazard_pkg;

    localparam int SEL_REGFILE = 0;
    localparam int STG_EXE     = 1;
    localparam int STG_MEM     = 2;
    localparam int STG_WB      = 3;

    // Widest register address the tag pipeline can carry; narrower addresses are zero-extended.
    localparam int REG_AW_MAX  = 8;

    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] dest;
        logic                  ld;
    } dest_tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - per-source stage match and youngest-producer select (honours R0_ZERO_EN)
module fwd_src_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DEPTH  = 3,
    parameter int SELW   = 2
) (
    input  logic [REG_AW-1:0]     src_addr,
    input  logic                  src_used,
    input  dest_tag_t [DEPTH-1:0] tags,
    output logic [SELW-1:0]       sel,
    output logic                  ld_match
);

    localparam logic [DEPTH-1:0] EXE_MASK = DEPTH'(1) << (STG_EXE - 1);

    logic [REG_AW_MAX-1:0] src_ext;
    logic                  src_ok;
    logic [DEPTH-1:0]      hit;
    logic [DEPTH-1:0]      ld_vec;

    assign src_ext = REG_AW_MAX'(src_addr);

`ifdef R0_ZERO_EN
    assign src_ok = src_used & (src_addr != '0);
`else
    assign src_ok = src_used;
`endif

    always_comb begin
        hit    = '0;
        ld_vec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k]    = src_ok & tags[k].v & (tags[k].dest == src_ext);
            ld_vec[k] = tags[k].ld;
        end
    end

    // Scan oldest to youngest so the lowest matching stage is written last and wins.
    always_comb begin
        sel = SELW'(SEL_REGFILE);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SELW'(k + 1);
            end
        end
    end

    assign ld_match = |(hit & ld_vec & EXE_MASK);

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - destination-tag pipeline, forwarding selects and load-use stall (option: R0_ZERO_EN)
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3,
    parameter int SELW   = clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src_addr,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]      id_dest_addr,
    input  logic                   id_dest_we,
    input  logic                   id_is_load,
    input  logic                   hold,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall
);

    dest_tag_t [DEPTH-1:0] stage_q;
    logic [NSRC*SELW-1:0]  sel_flat;
    logic [NSRC-1:0]       ld_match;
    logic                  stall_int;
    logic                  dest_ok;
    logic                  iss_v;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_src_select #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SELW   (SELW)
        ) u_sel (
            .src_addr (id_src_addr[i*REG_AW +: REG_AW]),
            .src_used (id_src_used[i]),
            .tags     (stage_q),
            .sel      (sel_flat[i*SELW +: SELW]),
            .ld_match (ld_match[i])
        );
    end

`ifdef R0_ZERO_EN
    assign dest_ok = (id_dest_addr != '0);
`else
    assign dest_ok = 1'b1;
`endif

    assign stall_int = id_valid & ~flush & (|ld_match);
    // A stalled or flushed instruction issues a bubble so it is never seen as a producer.
    assign iss_v     = id_valid & id_dest_we & dest_ok & ~stall_int & ~flush;

    assign fwd_sel = reset ? '0 : sel_flat;
    assign stall   = reset ? 1'b0 : stall_int;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (!hold) begin
            stage_q[0].v    <= iss_v;
            stage_q[0].dest <= REG_AW_MAX'(id_dest_addr);
            stage_q[0].ld   <= id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed checks of forwarding selects, stall, hold, flush and reset
module tb_hazard_fwd_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [2:0] id_dest_addr;
    logic       id_dest_we;
    logic       id_is_load;
    logic       hold;
    logic       flush;
    logic [3:0] fwd_sel;
    logic       stall;

    int checks   = 0;
    int failures = 0;

    hazard_fwd_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src_addr  (id_src_addr),
        .id_src_used  (id_src_used),
        .id_dest_addr (id_dest_addr),
        .id_dest_we   (id_dest_we),
        .id_is_load   (id_is_load),
        .hold         (hold),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] s0, input logic u0,
                          input logic [2:0] s1, input logic u1,
                          input logic [2:0] d, input logic we, input logic ld);
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = {u1, u0};
        id_dest_addr = d;
        id_dest_we   = we;
        id_is_load   = ld;
    endtask

    task automatic expect_out(input string tag, input int s0, input int s1, input int st);
        #1;
        check({tag, ".sel0"},  32'(fwd_sel[1:0]), 32'(s0));
        check({tag, ".sel1"},  32'(fwd_sel[3:2]), 32'(s1));
        check({tag, ".stall"}, 32'(stall),        32'(st));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1, 5, 1, 5, 1, 5, 1, 1);
        repeat (2) tick();
        expect_out("rst_forced", 0, 0, 0);
        reset = 1'b0;

        // Back-to-back ALU dependency, then the same producer two stages later.
        set_id(1, 1, 1, 2, 1, 5, 1, 0); expect_out("empty", 0, 0, 0); tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0); expect_out("alu_b2b", 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0); expect_out("store", 0, 0, 0); tick();
        set_id(1, 5, 1, 6, 1, 0, 0, 0); expect_out("alu_dist", 3, 2, 0); tick();
        set_id(1, 3, 1, 0, 0, 5, 1, 0); expect_out("nomatch", 0, 0, 0); tick();

        // r5 in stages 1 and 3, r1 in stage 2.
        set_id(1, 0, 0, 0, 0, 1, 1, 0); tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 0); tick();
        set_id(1, 1, 1, 5, 1, 0, 0, 0); expect_out("priority", 2, 1, 0); tick();

        // Load-use on src1, then a later reader.
        set_id(1, 5, 1, 0, 0, 2, 1, 1); expect_out("ld_issue", 2, 0, 0); tick();
        set_id(1, 0, 0, 2, 1, 3, 1, 0); expect_out("ld_use_stall", 0, 1, 1); tick();
        expect_out("ld_use_fwd", 0, 2, 0); tick();
        set_id(1, 2, 1, 0, 0, 0, 0, 0); expect_out("ld_2nd_reader", 3, 0, 0); tick();

        // Hold for three cycles while the load-use stall is active.
        set_id(1, 0, 0, 0, 0, 4, 1, 1); tick();
        set_id(1, 4, 1, 3, 1, 7, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("hold_stall", 1, 3, 1);
            tick();
        end
        hold = 1'b0;
        expect_out("hold_release", 1, 3, 1); tick();
        expect_out("hold_fwd", 2, 0, 0); tick();

        // Flush the dependent of a load: no stall, its dest r6 never tracked.
        set_id(1, 0, 0, 0, 0, 1, 1, 1); tick();
        set_id(1, 1, 1, 0, 0, 6, 1, 0);
        flush = 1'b1;
        expect_out("flush", 1, 0, 0); tick();
        flush = 1'b0;
        set_id(1, 6, 1, 1, 1, 0, 0, 0); expect_out("flush_gone_a", 0, 2, 0); tick();
        expect_out("flush_gone_b", 0, 3, 0); tick();

        // Reset with three valid tags in flight.
        set_id(1, 0, 0, 0, 0, 1, 1, 0); tick();
        set_id(1, 0, 0, 0, 0, 2, 1, 0); tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 1, 1, 3, 1, 0, 0, 0); expect_out("pre_reset", 3, 1, 1);
        reset = 1'b1;
        expect_out("in_reset", 0, 0, 0); tick();
        reset = 1'b0;
        expect_out("post_reset", 0, 0, 0); tick();

        // Load into r0, then read r0.
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 1, 0, 0, 0, 0, 0);
`ifdef R0_ZERO_EN
        expect_out("r0_read", 0, 0, 0);
`else
        expect_out("r0_read", 1, 0, 1);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding and load-use interlock unit for the pipelined RISC core. It sits beside the decode stage and tracks the destination register of every instruction in flight through EXE, MEM and WB. For each decode-stage source operand it produces a forwarding select, and it stalls decode for one cycle on a load-use hazard. It generalises the per-operand address comparator to N sources and D tracked stages, with its own registered destination-tag pipeline, hold/flush control and load interlock.

## Interface
- REG_AW, default 3: register address width.
- NSRC, default 2: number of decode-stage source operands.
- DEPTH, default 3: tracked stages after decode; stage 1 = EXE, 2 = MEM, 3 = WB.
- SELW, default clog2(DEPTH+1) (= 2): forwarding select width. Derived; do not override.

- clk  in  1  the single clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode holds a valid instruction.
- id_src_addr  in  NSRC*REG_AW  source register addresses; source i occupies bits [i*REG_AW +: REG_AW].
- id_src_used  in  NSRC  source i is actually read.
- id_dest_addr  in  REG_AW  destination register.
- id_dest_we  in  1  instruction writes id_dest_addr.
- id_is_load  in  1  instruction is a memory load.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  squash the decode-stage instruction.
- fwd_sel  out  NSRC*SELW  per-source select: 0 = register file, k = stage k result.
- stall  out  1  decode must hold its instruction this cycle.

## Operation
- State: per stage k, a tag {v, dest, ld}. No other state.
- Issue: iss_v = id_valid & id_dest_we & ~stall & ~flush.
- Advance, when hold=0 at the clock edge:
  - stage1 <= {iss_v, id_dest_addr, id_is_load}.
  - stage k <= stage k-1, for k = 2..DEPTH.
  - The tag leaving stage DEPTH is discarded.
- hold=1: all tags keep their values; outputs are still evaluated combinationally from the held tags.
- Match, for source i and stage k: id_src_used[i] & stage_k.v & (id_src_addr[i] == stage_k.dest).
- fwd_sel[i]: the smallest k that matches, so the youngest producer wins. 0 if no stage matches.
- stall = id_valid & ~flush & (any i matches stage 1 with stage1.ld = 1).
  - While stall is high, fwd_sel remains defined by the rule above, but decode does not consume it.
- Stall rule: a stall inserts a bubble (stage1.v = 0) on the next advance.
  - The load then sits in stage 2, so the dependent instruction re-evaluates with sel = 2 and stall = 0.
  - A single load-use costs exactly one stall cycle.
- Instruction with id_dest_we = 0 (store, branch): issues a tag with v = 0.
- Flush: forces stall = 0 and iss_v = 0 that cycle. Tags already in stages 1..DEPTH are unaffected.

## Timing
- fwd_sel and stall are combinational from the registered tags and the id_* inputs, with zero latency. No input-to-output path runs through a clock.
- A tag issued at edge n is visible as stage 1 in cycle n+1 and as stage k in cycle n+k (without hold).
- Reset:
  - reset high at an edge clears every stage v to 0; dest and ld are don't-care.
  - While reset is high, fwd_sel = 0 and stall = 0, forced regardless of inputs.
  - Reset asserted mid-stream drops all in-flight tags; no forwarding occurs in the first cycle after reset.
- Simultaneous events:
  - reset > hold > advance.
  - flush together with hold: tags are held, stall = 0.
  - stall together with hold: tags are held, no bubble is inserted, and stall stays asserted.
- Equal dest in several stages: the lowest k wins.
- Source matching a stage-2-or-later load: forwarded, no stall.

## Configuration
- R0_ZERO_EN
  - Defined: register address 0 is hardwired zero. A source with address 0 never matches (sel = 0, never causes stall), and a destination of 0 issues v = 0.
  - Undefined: register 0 is an ordinary register and is tracked and forwarded like any other.

## Structure
- Package hazard_pkg contains:
  - constant SEL_REGFILE = 0;
  - stage index constants STG_EXE = 1, STG_MEM = 2, STG_WB = 3;
  - typedef dest_tag_t {v, dest[REG_AW-1:0], ld};
  - function clog2.
- Sub-module fwd_src_select, instantiated NSRC times:
  - inputs: one source address, its used bit, and all DEPTH tags;
  - outputs: that source's priority-encoded select and its stage-1-load-match bit.
- Top level holds the tag registers, the issue/advance logic and the stall OR-reduction.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: issue r5 <- ..., then an instruction reading r5 as src0.
  - Required: sel0 = 1, stall = 0. Two cycles later a reader of r5 sees sel0 = 3.
- Priority: r5 is written in stages 1 and 3.
  - Required: reader of r5 gets sel = 1. With DEPTH = 3 and no match anywhere, sel = 0.
- Load-use: load r2, then add reading r2 on src1.
  - Required: stall = 1 for exactly one cycle, then sel1 = 2 with stall = 0.
  - A second reader issued one cycle later gets sel = 3.
- Hold during load-use:
  - Stimulus: hold = 1 for 3 cycles while stall is active.
  - Required: stall stays 1 and the tags are unchanged. After hold drops: one more stall cycle, then sel = 2.
- Flush and reset:
  - Flush while a load-use dependency is present: stall = 0, and the squashed instruction's dest never appears in any stage.
  - Assert reset with 3 tags valid: next cycle all sel = 0 and stall = 0.
- R0_ZERO_EN:
  - Stimulus: write r0, then read r0.
  - Required with the macro defined: sel = 0, stall = 0 even when r0 was loaded. Without the macro: sel = 1.
